window_preparation_kxk: RTL
===========================

// Module: window_preparation_kxk
// PURPOSE
//  Parametrised successor of the 3x3 Preparation stage. Converts a raster pixel stream into KxK
//  neighbourhood windows for the median/filter cores. Adds kernel size K, data width, zero-pad
//  border mode with self-inserted virtual pixels (input stalled via ready_o), frame coordinates
//  and an end-of-frame marker.
// PARAMETERS
//  DATA_W    8    pixel width in bits
//  IMG_W     640  pixels per line
//  IMG_H     480  lines per frame
//  K         3    window size; legal values 3 or 5; P = K/2
//  PAD_MODE  1    0 = VALID (interior centres only), 1 = ZERO (one window per pixel, zero border)
// PORTS
//  clk       in   1            clock, rising edge
//  rst       in   1            synchronous active-high reset
//  done_i    in   1            input pixel strobe; accepted when done_i & ready_o
//  data_i    in   DATA_W       input pixel, raster order
//  ready_o   out  1            block can accept a real pixel this cycle
//  done_o    out  1            window_o/row_o/col_o valid (single-cycle pulse)
//  window_o  out  K*K*DATA_W   element k=i*K+j (i row top->bottom, j col left->right) at [k*DATA_W +: DATA_W]
//  row_o     out  clog2(IMG_H) window centre row
//  col_o     out  clog2(IMG_W) window centre column
//  last_o    out  1            high with done_o on the final window of the frame
// BEHAVIOUR
//  - Reset: done_o=0, last_o=0, window_o=0, row_o=0, col_o=0, ready_o=1, counters (vr,vc)=(0,0).
//    Line-buffer contents are not cleared; stale data is always masked (see masking).
//  - Virtual raster (vr,vc): PAD_MODE=1 -> (IMG_H+P) x (IMG_W+P); PAD_MODE=0 -> IMG_H x IMG_W.
//    Position is real if vr<IMG_H && vc<IMG_W, otherwise virtual (value 0).
//  - FSM: ST_REAL (ready_o=1, advance on done_i) -> ST_PAD_COL at vc==IMG_W (P cycles, ready_o=0)
//    -> ST_REAL on the next row, or ST_PAD_ROW after the last real row (P*(IMG_W+P) cycles, ready_o=0)
//    -> ST_REAL with (vr,vc)=(0,0). Virtual positions advance one per cycle, independent of done_i.
//  - Each processed position shifts the pixel into the line buffers and the KxK shift window.
//    Column wrap at row end; row wrap at frame end.
//  - Emission: the position (vr,vc) yields centre (r,c)=(vr-P,vc-P) when r>=0 && c>=0.
//    PAD_MODE=0 additionally requires P<=r<=IMG_H-1-P and P<=c<=IMG_W-1-P.
//    done_o rises 1 cycle after the triggering position is processed. No output backpressure.
//  - Masking (PAD_MODE=1): element (i,j) maps to image pixel (r-P+i, c-P+j). It is forced to 0 when
//    row<0, row>=IMG_H, col<0 or col>=IMG_W. This covers previous-row wrap, previous-frame and stale rows.
//  - Window count per frame: IMG_W*IMG_H (ZERO) or (IMG_W-K+1)*(IMG_H-K+1) (VALID).
//    last_o is set on centre (IMG_H-1,IMG_W-1) or (IMG_H-1-P,IMG_W-1-P) respectively.
//  - done_i while ready_o=0: ignored; the pixel is not consumed and the source holds it.
//  - Reset mid-frame: abort at once. The next accepted pixel is (0,0) of a new frame, with no output
//    from the aborted frame after reset.
//  - Back-to-back frames: a new frame's first pixel can be accepted the cycle after ST_PAD_ROW ends
//    (ZERO) or right after the last pixel (VALID).
// STRUCTURE
//  - Shared package: PAD_VALID/PAD_ZERO constants, FSM state encodings (ST_REAL, ST_PAD_COL,
//    ST_PAD_ROW), and a clog2 function.
//  - Sub-module line_buffer (DATA_W, DEPTH=IMG_W+P): single-port shift/RAM delay line with enable.
//    K-1 instances are chained. The top level holds the counters, FSM, KxK register window and mask logic.
// TESTING  (small config IMG_W=4, IMG_H=3, K=3 unless stated; pixels 1..12 raster)
//  1 ZERO, back-to-back input:
//    - first window (0,0) = [0,0,0,0,1,2,0,5,6];
//    - window (1,1) = [1,2,3,5,6,7,9,10,11];
//    - last (2,3) = [7,8,0,11,12,0,0,0,0] with last_o;
//    - exactly 12 done_o pulses;
//    - ready_o low for 1 cycle after pixels 4 and 8, and 6 cycles after pixel 12.
//  2 VALID, same stimulus:
//    - exactly 2 windows: (1,1)=[1,2,3,5,6,7,9,10,11] and (1,2)=[2,3,4,6,7,8,10,11,12] with last_o;
//    - ready_o constantly 1.
//  3 ZERO, random 0-3 idle cycles between strobes and done_i held high during ready_o=0:
//    window sequence identical to scenario 1, no pixel lost or duplicated.
//  4 Reset after 6 pixels, then frame 101..112:
//    - no done_o during reset;
//    - first window [0,0,0,0,101,102,0,105,106];
//    - 12 windows total.
//  5 Two consecutive ZERO frames (1..12 then 201..212): second frame window (0,0) = [0,0,0,0,201,202,0,205,206],
//    no stale frame-1 values anywhere in frame 2.
//  6 K=5, IMG_W=6, IMG_H=5, ZERO:
//    - window (0,0) rows 0-1 and cols 0-1 are zero; element 12 = 1, 13 = 2, 18 = 8;
//    - 30 windows; last_o on (4,5).

Source files
------------

// File: rtl/window_preparation_kxk_pkg.sv
// Shared constants, FSM state encodings and a width helper for the KxK window preparation stage.
package window_preparation_kxk_pkg;

   localparam int PAD_VALID = 0;
   localparam int PAD_ZERO  = 1;

   typedef enum logic [1:0] {
      ST_REAL    = 2'd0,
      ST_PAD_COL = 2'd1,
      ST_PAD_ROW = 2'd2
   } state_e;

   // Never returns less than 1 so that degenerate sizes still give a legal vector width.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/window_preparation_kxk_if.sv
// Pixel-in / window-out bundle of the window preparation stage; slave is the block, master the source/sink.
interface window_preparation_kxk_if #(
   parameter int DATA_W = 8,
   parameter int K      = 3,
   parameter int ROW_W  = 9,
   parameter int COL_W  = 10
);
   logic                  done_i;
   logic [DATA_W-1:0]     data_i;
   logic                  ready_o;
   logic                  done_o;
   logic [K*K*DATA_W-1:0] window_o;
   logic [ROW_W-1:0]      row_o;
   logic [COL_W-1:0]      col_o;
   logic                  last_o;

   modport master (
      output done_i, data_i,
      input  ready_o, done_o, window_o, row_o, col_o, last_o
   );

   modport slave (
      input  done_i, data_i,
      output ready_o, done_o, window_o, row_o, col_o, last_o
   );
endinterface

// File: rtl/window_preparation_kxk_line_buffer.sv
// One-line delay: every enabled sample reappears on data_o exactly DEPTH enables later.
module window_preparation_kxk_line_buffer
   import window_preparation_kxk_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 641
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o
);
   localparam int PTR_W = clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d;

   // Read-before-write on the same slot yields the sample written one full lap ago.
   assign data_o = mem[ptr_q];

   always_comb begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (en_i) begin
         ptr_q <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (en_i) begin
         mem[ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/window_preparation_kxk.sv
// Raster-to-KxK window converter: virtual-raster counters and FSM, chained line buffers,
// a KxK shift window and border masking for zero padding. K must be 3 or 5.
module window_preparation_kxk
   import window_preparation_kxk_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480,
   parameter int K        = 3,
   parameter int PAD_MODE = PAD_ZERO
) (
   input logic                     clk,
   input logic                     rst,
   window_preparation_kxk_if.slave bus
);
   localparam int P     = K / 2;
   localparam int VW    = (PAD_MODE == PAD_ZERO) ? IMG_W + P : IMG_W;
   localparam int VH    = (PAD_MODE == PAD_ZERO) ? IMG_H + P : IMG_H;
   localparam int VR_W  = clog2(VH + 1);
   localparam int VC_W  = clog2(VW + 1);
   localparam int ROW_W = clog2(IMG_H);
   localparam int COL_W = clog2(IMG_W);
   localparam int WIN_W = K * K * DATA_W;

   state_e            state_q, state_d;
   logic              ready_q;
   logic [VR_W-1:0]   vr_q, vr_d;
   logic [VC_W-1:0]   vc_q, vc_d;
   logic              proc;
   logic [DATA_W-1:0] pix;

   logic [DATA_W-1:0] lbIn  [K-1];
   logic [DATA_W-1:0] lbOut [K-1];
   logic [DATA_W-1:0] rowIn [K];
   logic [DATA_W-1:0] win_q [K][K];
   logic [DATA_W-1:0] win_d [K][K];

   logic [K-1:0]      rowOk, colOk;
   logic              emit, isLast;
   logic              done_q, last_q;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [WIN_W-1:0]  window_q, window_d;

   // Virtual positions are consumed one per cycle; real ones only on an accepted strobe.
   assign proc = (state_q == ST_REAL) ? bus.done_i : 1'b1;
   assign pix  = (state_q == ST_REAL) ? bus.data_i : '0;

   always_comb begin
      vr_d = vr_q;
      vc_d = vc_q;
      if (proc) begin
         if (vc_q == VC_W'(VW - 1)) begin
            vc_d = '0;
            vr_d = (vr_q == VR_W'(VH - 1)) ? '0 : vr_q + 1'b1;
         end else begin
            vc_d = vc_q + 1'b1;
         end
      end
      if (vr_d >= VR_W'(IMG_H)) begin
         state_d = ST_PAD_ROW;
      end else if (vc_d >= VC_W'(IMG_W)) begin
         state_d = ST_PAD_COL;
      end else begin
         state_d = ST_REAL;
      end
   end

   always_comb begin
      lbIn[0] = pix;
      for (int g = 1; g < K - 1; g++) begin
         lbIn[g] = lbOut[g - 1];
      end
   end

   for (genvar g = 0; g < K - 1; g++) begin : g_lb
      window_preparation_kxk_line_buffer #(
         .DATA_W (DATA_W),
         .DEPTH  (VW)
      ) u_lb (
         .clk    (clk),
         .rst    (rst),
         .en_i   (proc),
         .data_i (lbIn[g]),
         .data_o (lbOut[g])
      );
   end

   // Bottom window row takes the live pixel; each row above comes from one more line of delay.
   always_comb begin
      rowIn[K - 1] = pix;
      for (int i = 0; i < K - 1; i++) begin
         rowIn[i] = lbOut[K - 2 - i];
      end
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K - 1; j++) begin
            win_d[i][j] = win_q[i][j + 1];
         end
         win_d[i][K - 1] = rowIn[i];
      end
   end

   always_comb begin
      int pr;
      int pc;
      rowOk    = '0;
      colOk    = '0;
      window_d = '0;
      if (PAD_MODE == PAD_ZERO) begin
         emit = proc && (vr_q >= VR_W'(P)) && (vc_q >= VC_W'(P));
      end else begin
         emit = proc && (vr_q >= VR_W'(K - 1)) && (vc_q >= VC_W'(K - 1));
      end
      isLast = (vr_q == VR_W'(VH - 1)) && (vc_q == VC_W'(VW - 1));
      // Out-of-image taps hold previous-row wrap, previous-frame or stale line-buffer data.
      for (int i = 0; i < K; i++) begin
         pr       = int'(vr_q) - (K - 1) + i;
         rowOk[i] = (PAD_MODE == PAD_VALID) || ((pr >= 0) && (pr < IMG_H));
      end
      for (int j = 0; j < K; j++) begin
         pc       = int'(vc_q) - (K - 1) + j;
         colOk[j] = (PAD_MODE == PAD_VALID) || ((pc >= 0) && (pc < IMG_W));
      end
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            window_d[(i * K + j) * DATA_W +: DATA_W] = (rowOk[i] && colOk[j]) ? win_d[i][j] : '0;
         end
      end
      row_d = ROW_W'(int'(vr_q) - P);
      col_d = COL_W'(int'(vc_q) - P);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_REAL;
         ready_q  <= 1'b1;
         vr_q     <= '0;
         vc_q     <= '0;
         done_q   <= 1'b0;
         last_q   <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
         window_q <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == ST_REAL);
         vr_q    <= vr_d;
         vc_q    <= vc_d;
         done_q  <= emit;
         last_q  <= emit && isLast;
         if (emit) begin
            row_q    <= row_d;
            col_q    <= col_d;
            window_q <= window_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (proc) begin
         win_q <= win_d;
      end
   end

   assign bus.ready_o  = ready_q;
   assign bus.done_o   = done_q;
   assign bus.last_o   = last_q;
   assign bus.row_o    = row_q;
   assign bus.col_o    = col_q;
   assign bus.window_o = window_q;

endmodule
